// File: rtl/ldm_stm_addr_seq.sv
// Load/store address sequencer: walks single or LDM/STM block transfers over a req/ack memory port.
// Build option ADDR_SEQ_ALIGN_CHECK_EN: block commands with a misaligned base fault instead of issuing.
//
// state  | meaning
// S_IDLE | waiting for start_in; command inputs are sampled only here
// S_XFER | presenting the current transfer, advancing on mem_ack_in
// S_DONE | one-cycle completion: done, base writeback or alignment fault
module ldm_stm_addr_seq #(
  parameter int ADDR_W     = 32,
  parameter int NREGS      = 16,
  parameter int IDX_W      = 4,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              start_in,
  input  logic              multiple_in,
  input  logic              pre_in,
  input  logic              up_in,
  input  logic              wb_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W-1:0] offset_in,
  input  logic [NREGS-1:0]  reg_list_in,
  input  logic              abort_in,
  input  logic              mem_ack_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] addr_to_mem_out,
  output logic [IDX_W-1:0]  reg_idx_out,
  output logic              last_out,
  output logic              busy_out,
  output logic              wb_en_out,
  output logic [ADDR_W-1:0] wb_data_out,
  output logic              done_out,
  output logic              fault_out
);

  localparam int CNT_W = $clog2(NREGS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREGS-1:0]  list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_val_q, wb_val_d;
  logic [ADDR_W-1:0] wb_data_q, wb_data_d;
  logic              multiple_q, multiple_d;
  logic              wb_q, wb_d;
  logic              fault_q, fault_d;

  logic [CNT_W-1:0]  pop_cnt;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] sum_single;
  logic [ADDR_W-1:0] blk_lo;
  logic [ADDR_W-1:0] blk_wb;
  logic [IDX_W-1:0]  cur_idx;
  logic [NREGS-1:0]  list_rest;
  logic              xfer_last;
  logic              align_fault;

  assign step = ADDR_W'(WORD_BYTES);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      pop_cnt = pop_cnt + CNT_W'(reg_list_in[i]);
    end
  end

  // Block transfers always run at ascending addresses, so only the lowest address matters.
  always_comb begin
    span       = ADDR_W'(pop_cnt) * step;
    sum_single = up_in ? (base_addr_in + offset_in) : (base_addr_in - offset_in);
    if (up_in) begin
      blk_lo = pre_in ? (base_addr_in + step) : base_addr_in;
      blk_wb = base_addr_in + span;
    end else begin
      blk_lo = pre_in ? (base_addr_in - span) : (base_addr_in - span + step);
      blk_wb = base_addr_in - span;
    end
  end

`ifdef ADDR_SEQ_ALIGN_CHECK_EN
  assign align_fault = multiple_in & (base_addr_in[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  always_comb begin
    cur_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list_q[i]) cur_idx = IDX_W'(i);
    end
  end

  assign list_rest = list_q & (list_q - NREGS'(1));
  assign xfer_last = !multiple_q || (list_rest == '0);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= S_IDLE;
      list_q     <= '0;
      addr_q     <= '0;
      wb_val_q   <= '0;
      wb_data_q  <= '0;
      multiple_q <= 1'b0;
      wb_q       <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      wb_val_q   <= wb_val_d;
      wb_data_q  <= wb_data_d;
      multiple_q <= multiple_d;
      wb_q       <= wb_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    addr_d     = addr_q;
    wb_val_d   = wb_val_q;
    wb_data_d  = wb_data_q;
    multiple_d = multiple_q;
    wb_d       = wb_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          multiple_d = multiple_in;
          wb_d       = wb_in;
          fault_d    = align_fault;
          if (multiple_in) begin
            list_d   = align_fault ? '0 : reg_list_in;
            addr_d   = blk_lo;
            wb_val_d = blk_wb;
          end else begin
            list_d   = '0;
            addr_d   = pre_in ? sum_single : base_addr_in;
            wb_val_d = sum_single;
          end
          if (align_fault) begin
            state_d = S_DONE;
          end else if (multiple_in && (reg_list_in == '0)) begin
            state_d   = S_DONE;
            wb_data_d = blk_wb;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (abort_in) begin
          state_d = S_IDLE;
        end else if (mem_ack_in) begin
          if (multiple_q) list_d = list_rest;
          if (xfer_last) begin
            state_d   = S_DONE;
            wb_data_d = wb_val_q;
          end else begin
            addr_d = addr_q + step;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // An abort arriving in S_DONE suppresses that cycle's completion strobes.
  always_comb begin
    mem_req_out     = (state_q == S_XFER);
    addr_to_mem_out = (state_q == S_XFER) ? addr_q : '0;
    reg_idx_out     = ((state_q == S_XFER) && multiple_q) ? cur_idx : '0;
    last_out        = (state_q == S_XFER) && xfer_last;
    busy_out        = (state_q != S_IDLE);
    done_out        = (state_q == S_DONE) && !abort_in;
    wb_en_out       = (state_q == S_DONE) && wb_q && !fault_q && !abort_in;
    fault_out       = (state_q == S_DONE) && fault_q && !abort_in;
    wb_data_out     = wb_data_q;
  end

endmodule

// File: tb/tb_ldm_stm_addr_seq.sv
// Self-checking bench for ldm_stm_addr_seq: transfer-list model plus per-cycle compare process.
// Honors ADDR_SEQ_ALIGN_CHECK_EN when the design is built with it.
module tb_ldm_stm_addr_seq;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        start_in, multiple_in, pre_in, up_in, wb_in;
  logic [31:0] base_addr_in, offset_in;
  logic [15:0] reg_list_in;
  logic        abort_in, mem_ack_in;
  logic        mem_req_out, last_out, busy_out, wb_en_out, done_out, fault_out;
  logic [31:0] addr_to_mem_out, wb_data_out;
  logic [3:0]  reg_idx_out;

  ldm_stm_addr_seq dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in),
    .multiple_in(multiple_in), .pre_in(pre_in), .up_in(up_in), .wb_in(wb_in),
    .base_addr_in(base_addr_in), .offset_in(offset_in), .reg_list_in(reg_list_in),
    .abort_in(abort_in), .mem_ack_in(mem_ack_in), .mem_req_out(mem_req_out),
    .addr_to_mem_out(addr_to_mem_out), .reg_idx_out(reg_idx_out), .last_out(last_out),
    .busy_out(busy_out), .wb_en_out(wb_en_out), .wb_data_out(wb_data_out),
    .done_out(done_out), .fault_out(fault_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  idx;
    logic        last;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] log_addr[$];
  logic [3:0]  log_idx[$];
  logic [31:0] exp_wb, held_wb, done_wb;
  logic        exp_wb_en, exp_fault, done_fault;
  bit          hold_ok;
  int          done_cnt;
  bit          chk_en;
  bit          done_due, done_due_nx, req_due, req_due_nx, idle_due, idle_due_nx;
  int          n_chk, n_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
  endtask

  function automatic logic [31:0] la(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] li(input int i);
    return (i < log_idx.size()) ? {28'd0, log_idx[i]} : 32'hFFFF_FFFF;
  endfunction

  // Expected transfer list from the addressing rules: lowest register at lowest address.
  task automatic build_model(input logic mult, pre, up, wb, input logic [31:0] base, off,
                             input logic [15:0] list);
    int    n, k;
    xfer_t x;
    exp_q.delete();
    log_addr.delete();
    log_idx.delete();
    n = $countones(list);
    k = 0;
    exp_fault = 1'b0;
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    exp_fault = mult && (base[1:0] != 2'b00);
`endif
    if (!mult) begin
      x.addr = pre ? (up ? base + off : base - off) : base;
      x.idx  = 4'd0;
      x.last = 1'b1;
      exp_q.push_back(x);
      exp_wb = up ? base + off : base - off;
    end else begin
      exp_wb = up ? base + 32'(4 * n) : base - 32'(4 * n);
      if (!exp_fault) begin
        for (int i = 0; i < 16; i++) begin
          if (list[i]) begin
            x.addr = up ? base + 32'(4 * k) + (pre ? 32'd4 : 32'd0)
                        : base - 32'(4 * (n - k)) + (pre ? 32'd0 : 32'd4);
            x.idx  = 4'(i);
            x.last = (k == n - 1);
            exp_q.push_back(x);
            k++;
          end
        end
      end
    end
    exp_wb_en = wb && !exp_fault;
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      done_due = done_due_nx; done_due_nx = 0;
      req_due  = req_due_nx;  req_due_nx  = 0;
      idle_due = idle_due_nx; idle_due_nx = 0;
      if (req_due)  chk("first_req_latency", mem_req_out, 1'b1);
      if (idle_due) chk("idle_after_abort", busy_out, 1'b0);
      if (mem_req_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", mem_req_out, 1'b0);
        end else begin
          chk("addr", addr_to_mem_out, exp_q[0].addr);
          chk("reg_idx", reg_idx_out, exp_q[0].idx);
          chk("last", last_out, exp_q[0].last);
          if (mem_ack_in && !abort_in) begin
            log_addr.push_back(addr_to_mem_out);
            log_idx.push_back(reg_idx_out);
            if (exp_q[0].last) done_due_nx = 1;
            void'(exp_q.pop_front());
          end
        end
      end
      if (abort_in && busy_out) begin
        exp_q.delete();
        done_due_nx = 0;
        idle_due_nx = 1;
      end
      if (done_due) begin
        done_cnt++;
        done_wb    = wb_data_out;
        done_fault = fault_out;
        chk("done", done_out, 1'b1);
        chk("fault", fault_out, exp_fault);
        chk("wb_en", wb_en_out, exp_wb_en);
        if (exp_wb_en) chk("wb_data", wb_data_out, exp_wb);
        if (!exp_fault) begin
          held_wb = exp_wb;
          hold_ok = exp_wb_en;
        end
      end else begin
        chk("no_stray_strobe", {29'd0, done_out, wb_en_out, fault_out}, 32'd0);
        if (!busy_out && hold_ok) chk("wb_data_hold", wb_data_out, held_wb);
      end
      if (start_in && !busy_out) begin
        if (exp_q.size() == 0) done_due_nx = 1;
        else req_due_nx = 1;
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic run_cmd(input logic mult, pre, up, wb, input logic [31:0] base, off,
                         input logic [15:0] list, input int ack_per, input int abort_after,
                         input logic abort_at_start);
    int cyc, acks;
    bit finished, aborted, stray;
    build_model(mult, pre, up, wb, base, off, list);
    stray = (exp_q.size() >= 3);
    start_in = 1'b1; multiple_in = mult; pre_in = pre; up_in = up; wb_in = wb;
    base_addr_in = base; offset_in = off; reg_list_in = list;
    abort_in = abort_at_start; mem_ack_in = 1'b0;
    @(posedge clk_in); #1;
    start_in = 1'b0; abort_in = 1'b0;
    base_addr_in = 32'hDEAD_BEEC; offset_in = 32'h0000_1230; reg_list_in = 16'hA5A5;
    multiple_in = ~mult; pre_in = ~pre; up_in = ~up; wb_in = ~wb;
    cyc = 0; acks = 0; finished = 0; aborted = 0;
    while (!finished && cyc < 300) begin
      mem_ack_in = (ack_per <= 1) ? 1'b1 : ((cyc % ack_per) == ack_per - 1);
      abort_in   = (abort_after >= 0) && (acks >= abort_after) && !aborted;
      if (abort_in) aborted = 1;
      start_in = stray && (cyc == 1);
      @(negedge clk_in);
      if (mem_req_out && mem_ack_in && !abort_in) acks++;
      if (!busy_out) finished = 1;
      @(posedge clk_in); #1;
      cyc++;
    end
    start_in = 1'b0; abort_in = 1'b0; mem_ack_in = 1'b0;
    chk("cmd_completes", {31'd0, finished}, 32'd1);
    chk("xfers_left", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    n_chk = 0; n_pass = 0; chk_en = 0; done_cnt = 0;
    held_wb = '0; hold_ok = 1; done_wb = '0; done_fault = 1'b0;
    reset_n_in = 1'b0; start_in = 0; multiple_in = 0; pre_in = 0; up_in = 0; wb_in = 0;
    base_addr_in = '0; offset_in = '0; reg_list_in = '0; abort_in = 0; mem_ack_in = 0;
    #12;
    chk("rst_req", mem_req_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_addr", addr_to_mem_out, 32'd0);
    chk("rst_wb_data", wb_data_out, 32'd0);
    chk("rst_strobes", {28'd0, done_out, wb_en_out, fault_out, last_out}, 32'd0);
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;
    chk_en = 1;

    // increment-after, ack held
    run_cmd(1, 0, 1, 1, 32'h100, 0, 16'h000B, 1, -1, 0);
    chk("ia_nxfer", log_addr.size(), 3);
    chk("ia_a0", la(0), 32'h100); chk("ia_a1", la(1), 32'h104); chk("ia_a2", la(2), 32'h108);
    chk("ia_i0", li(0), 0); chk("ia_i1", li(1), 1); chk("ia_i2", li(2), 3);
    chk("ia_wb", done_wb, 32'h10C);

    // decrement-before
    run_cmd(1, 1, 0, 1, 32'h200, 0, 16'h8001, 1, -1, 0);
    chk("db_a0", la(0), 32'h1F8); chk("db_i0", li(0), 0);
    chk("db_a1", la(1), 32'h1FC); chk("db_i1", li(1), 15);
    chk("db_wb", done_wb, 32'h1F8);

    // single pre-add and post-sub
    run_cmd(0, 1, 1, 1, 32'h40, 32'h8, 16'h0000, 1, -1, 0);
    chk("spa_nxfer", log_addr.size(), 1);
    chk("spa_addr", la(0), 32'h48); chk("spa_wb", done_wb, 32'h48);
    run_cmd(0, 0, 0, 1, 32'h40, 32'h8, 16'h0000, 2, -1, 0);
    chk("sps_addr", la(0), 32'h40); chk("sps_wb", done_wb, 32'h38);

    // stalls and address wrap
    run_cmd(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 16'h0003, 3, -1, 0);
    chk("wrap_a0", la(0), 32'hFFFF_FFFC); chk("wrap_a1", la(1), 32'h0);
    chk("wrap_wb", done_wb, 32'h4);

    // abort after first ack (abort and ack together: abort wins)
    d0 = done_cnt;
    run_cmd(1, 1, 1, 1, 32'h300, 0, 16'h00F0, 1, 1, 0);
    chk("abort_nxfer", log_addr.size(), 1);
    chk("abort_a0", la(0), 32'h304); chk("abort_i0", li(0), 4);
    chk("abort_no_done", done_cnt, d0);

    // empty list
    d0 = done_cnt;
    run_cmd(1, 0, 1, 1, 32'h100, 0, 16'h0000, 1, -1, 0);
    chk("empty_done", done_cnt, d0 + 1);
    chk("empty_wb", done_wb, 32'h100);

    // decrement-after, no writeback, ack every other cycle, stray start mid-command
    run_cmd(1, 0, 0, 0, 32'h1000, 0, 16'h0421, 2, -1, 0);
    chk("da_a0", la(0), 32'hFF8); chk("da_a2", la(2), 32'h1000); chk("da_i2", li(2), 10);

    // start and abort together in IDLE: start accepted
    run_cmd(0, 0, 1, 1, 32'h80, 32'h10, 16'h0000, 1, -1, 1);
    chk("sa_addr", la(0), 32'h80); chk("sa_wb", done_wb, 32'h90);

    // full list
    run_cmd(1, 0, 1, 1, 32'h0, 0, 16'hFFFF, 1, -1, 0);
    chk("full_nxfer", log_addr.size(), 16);
    chk("full_a15", la(15), 32'h3C); chk("full_i15", li(15), 15);
    chk("full_wb", done_wb, 32'h40);

    // misaligned block base
    run_cmd(1, 0, 1, 1, 32'h102, 0, 16'h0003, 1, -1, 0);
`ifdef ADDR_SEQ_ALIGN_CHECK_EN
    chk("align_nxfer", log_addr.size(), 0);
    chk("align_fault", {31'd0, done_fault}, 32'd1);
`else
    chk("align_nxfer", log_addr.size(), 2);
    chk("align_a0", la(0), 32'h102);
`endif

    // abort in IDLE ignored
    abort_in = 1'b1;
    @(negedge clk_in);
    chk("abort_idle_busy", busy_out, 1'b0);
    @(posedge clk_in); #1;
    abort_in = 1'b0;
    @(negedge clk_in);
    chk("abort_idle_req", mem_req_out, 1'b0);
    @(posedge clk_in); #1;

    // reset in the middle of a stalled block transfer
    build_model(1, 0, 1, 1, 32'h500, 0, 16'h000F);
    start_in = 1'b1; multiple_in = 1; pre_in = 0; up_in = 1; wb_in = 1;
    base_addr_in = 32'h500; reg_list_in = 16'h000F; mem_ack_in = 0;
    @(posedge clk_in); #1;
    start_in = 1'b0; mem_ack_in = 1'b1;
    @(posedge clk_in); #1;
    mem_ack_in = 1'b0;
    @(negedge clk_in); #2;
    chk_en = 0;
    reset_n_in = 1'b0;
    #1;
    chk("mid_rst_req", mem_req_out, 1'b0);
    chk("mid_rst_busy", busy_out, 1'b0);
    chk("mid_rst_addr", addr_to_mem_out, 32'd0);
    chk("mid_rst_idx", reg_idx_out, 4'd0);
    chk("mid_rst_wb_data", wb_data_out, 32'd0);
    chk("mid_rst_strobes", {28'd0, done_out, wb_en_out, fault_out, last_out}, 32'd0);
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;
    exp_q.delete();
    done_due_nx = 0; req_due_nx = 0; idle_due_nx = 0;
    held_wb = '0; hold_ok = 1;
    chk_en = 1;

    // sequencer usable after reset
    run_cmd(1, 0, 1, 1, 32'h20, 0, 16'h0006, 1, -1, 0);
    chk("post_rst_a0", la(0), 32'h20); chk("post_rst_i0", li(0), 1);
    chk("post_rst_wb", done_wb, 32'h28);

    repeat (2) @(posedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
